// File: rtl/vmm_sequencer.sv
// -----------------------------------------------------------------------------
// vmm_sequencer
//   Control FSM for one vector-matrix product out[j] = sum_i x[i]*W[i][j] on the
//   shared MAC datapath. Column j is the outer loop and row i is the inner loop.
//   Each finished column sum is registered and offered on a valid/ready port.
//   A single-step mode lets a board key advance the sequence one move at a time.
//
// Ports
//   vmm_clk      clock
//   rst          asynchronous reset, active-high
//   start_i      begin a pass (looked at only in IDLE)
//   abort_i      abandon the pass and return to IDLE
//   step_en_i    1 = single-step mode
//   step_i       one-cycle advance pulse (used only in step mode)
//   x_addr_o     x memory address (= i)
//   w_addr_o     W memory address (= i*M + j)
//   mac_clr_o    clear the accumulator this cycle
//   mac_en_o     accumulate the memory read data this cycle
//   acc_i        registered accumulator value from the MAC
//   res_valid_o  column result valid
//   res_ready_i  consumer accepts the result
//   res_data_o   registered column result
//   res_col_o    column index of res_data_o
//   busy_o       high in every state except IDLE
//   done_o       high while in DONE (pass complete)
//   state_o      state code for the debug display
//   i_o, j_o     current indices for the debug display
// -----------------------------------------------------------------------------
module vmm_sequencer #(
  parameter int L     = 5,
  parameter int M     = 5,
  parameter int OUT_W = 10,
  parameter int IW    = $clog2(L),
  parameter int JW    = $clog2(M),
  parameter int WAW   = $clog2(L * M)
) (
  input  logic             vmm_clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             step_en_i,
  input  logic             step_i,
  output logic [IW-1:0]    x_addr_o,
  output logic [WAW-1:0]   w_addr_o,
  output logic             mac_clr_o,
  output logic             mac_en_o,
  input  logic [OUT_W-1:0] acc_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [OUT_W-1:0] res_data_o,
  output logic [JW-1:0]    res_col_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [2:0]       state_o,
  output logic [IW-1:0]    i_o,
  output logic [JW-1:0]    j_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FETCH = 3'd2,
    S_ACC   = 3'd3,
    S_DRAIN = 3'd4,
    S_OUT   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    i_q, i_d;
  logic [JW-1:0]    j_q, j_d;
  logic [IW-1:0]    x_addr_q, x_addr_d;
  logic [WAW-1:0]   w_addr_q, w_addr_d;
  logic [OUT_W-1:0] res_data_q, res_data_d;
  logic [JW-1:0]    res_col_q, res_col_d;
  logic             mac_clr_d;
  logic             mac_en_d;

  // In free-running mode every timed state advances each cycle; in step mode
  // only on a step pulse. IDLE and OUT ignore this.
  logic adv;
  assign adv = ~step_en_i | step_i;

  always_ff @(posedge vmm_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      x_addr_q   <= '0;
      w_addr_q   <= '0;
      res_data_q <= '0;
      res_col_q  <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      x_addr_q   <= x_addr_d;
      w_addr_q   <= w_addr_d;
      res_data_q <= res_data_d;
      res_col_q  <= res_col_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    x_addr_d   = x_addr_q;
    w_addr_d   = w_addr_q;
    res_data_d = res_data_q;
    res_col_d  = res_col_q;
    mac_clr_d  = 1'b0;
    mac_en_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = S_CLR;
          i_d     = '0;
          j_d     = '0;
        end
      end
      S_CLR: begin
        mac_clr_d = 1'b1;
        if (adv) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (adv) state_d = S_ACC;
      end
      S_ACC: begin
        // Gate the enable with adv so a long step-mode ACC adds its element once.
        mac_en_d = adv;
        if (adv) begin
          if (i_q == IW'(L - 1)) begin
            state_d = S_DRAIN;
          end else begin
            i_d     = i_q + IW'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        // The last accumulate landed at the end of ACC, so acc_i is final here.
        if (adv) begin
          res_data_d = acc_i;
          res_col_d  = j_q;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (res_ready_i) begin
          if (j_q == JW'(M - 1)) begin
            state_d = S_DONE;
          end else begin
            j_d     = j_q + JW'(1);
            i_d     = '0;
            state_d = S_CLR;
          end
        end
      end
      S_DONE: begin
        if (adv) state_d = S_IDLE;
      end
      default: begin
        // Unused code 7: recover to a clean IDLE.
        state_d = S_IDLE;
        i_d     = '0;
        j_d     = '0;
      end
    endcase

    // Abort outranks every other transition; the last result stays visible.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      i_d     = '0;
      j_d     = '0;
    end

    // Addresses are registered on entry to FETCH and otherwise hold, so the
    // one-cycle memory read lines up with ACC and nothing moves during DRAIN/OUT.
    if (state_d == S_FETCH) begin
      x_addr_d = i_d;
      w_addr_d = WAW'(i_d) * WAW'(M) + WAW'(j_d);
    end
  end

  assign x_addr_o    = x_addr_q;
  assign w_addr_o    = w_addr_q;
  assign mac_clr_o   = mac_clr_d;
  assign mac_en_o    = mac_en_d;
  assign res_valid_o = (state_q == S_OUT);
  assign res_data_o  = res_data_q;
  assign res_col_o   = res_col_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign state_o     = state_q;
  assign i_o         = i_q;
  assign j_o         = j_q;

endmodule

// File: tb/tb_vmm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vmm_sequencer
//   Bench for vmm_sequencer with L = M = 5, OUT_W = 10. It provides the x and
//   W memories (one-cycle registered read) and the MAC accumulator, and keeps
//   an arithmetic model of out[j] = sum_i x[i]*W[i][j] mod 2^OUT_W. A compare
//   process checks every accepted result and every accumulate cycle; the
//   directed sequence checks timing, backpressure, step mode, abort, ignored
//   starts and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_vmm_sequencer;

  localparam int L     = 5;
  localparam int M     = 5;
  localparam int OUT_W = 10;
  localparam int IW    = $clog2(L);
  localparam int JW    = $clog2(M);
  localparam int WAW   = $clog2(L * M);

  logic             vmm_clk = 1'b0;
  logic             rst;
  logic             start_i, abort_i, step_en_i, step_i, res_ready_i;
  logic [IW-1:0]    x_addr_o;
  logic [WAW-1:0]   w_addr_o;
  logic             mac_clr_o, mac_en_o;
  logic [OUT_W-1:0] acc_i;
  logic             res_valid_o;
  logic [OUT_W-1:0] res_data_o;
  logic [JW-1:0]    res_col_o;
  logic             busy_o, done_o;
  logic [2:0]       state_o;
  logic [IW-1:0]    i_o;
  logic [JW-1:0]    j_o;

  int checks   = 0;
  int failures = 0;

  vmm_sequencer #(.L(L), .M(M), .OUT_W(OUT_W)) dut (
    .vmm_clk    (vmm_clk),
    .rst        (rst),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .step_en_i  (step_en_i),
    .step_i     (step_i),
    .x_addr_o   (x_addr_o),
    .w_addr_o   (w_addr_o),
    .mac_clr_o  (mac_clr_o),
    .mac_en_o   (mac_en_o),
    .acc_i      (acc_i),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i),
    .res_data_o (res_data_o),
    .res_col_o  (res_col_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .state_o    (state_o),
    .i_o        (i_o),
    .j_o        (j_o)
  );

  always #5 vmm_clk = ~vmm_clk;

  // ---------------- environment: memories and MAC ----------------
  logic [OUT_W-1:0]   x_mem [0:(1<<IW)-1];
  logic [OUT_W-1:0]   w_mem [0:(1<<WAW)-1];
  logic [OUT_W-1:0]   x_rd, w_rd;
  logic [2*OUT_W-1:0] prod;
  assign prod = x_rd * w_rd;

  always @(posedge vmm_clk or posedge rst) begin
    if (rst) begin
      x_rd  <= '0;
      w_rd  <= '0;
      acc_i <= '0;
    end else begin
      x_rd <= x_mem[x_addr_o];
      w_rd <= w_mem[w_addr_o];
      if (mac_clr_o)     acc_i <= '0;
      else if (mac_en_o) acc_i <= acc_i + prod[OUT_W-1:0];
    end
  end

  // ---------------- model ----------------
  function automatic logic [OUT_W-1:0] model_out(input int j);
    int unsigned s;
    s = 0;
    for (int i = 0; i < L; i++) s += int'(x_mem[i]) * int'(w_mem[i*M + j]);
    return s[OUT_W-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- compare process ----------------
  int res_cnt  = 0;   // results accepted so far
  int en_cnt   = 0;   // accumulate cycles so far
  int done_cnt = 0;   // cycles with done_o high
  int pass_base = 0;  // res_cnt at the start of the current pass

  always @(negedge vmm_clk) begin
    if (!rst) begin
      if (mac_en_o) begin
        en_cnt++;
        chk("acc_x_addr", 32'(x_addr_o), 32'(i_o));
        chk("acc_w_addr", 32'(w_addr_o), 32'(int'(x_addr_o) * M + int'(j_o)));
      end
      if (done_o) done_cnt++;
      if (res_valid_o && res_ready_i) begin
        chk("res_col", 32'(res_col_o), 32'(res_cnt - pass_base));
        chk("res_data", 32'(res_data_o), 32'(model_out(res_cnt - pass_base)));
        $display("result col=%0d data=%0d", res_col_o, res_data_o);
        res_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int en_base, done_base;

  task automatic tick();
    @(posedge vmm_clk);
    #1;
  endtask

  task automatic mark();
    pass_base = res_cnt;
    en_base   = en_cnt;
    done_base = done_cnt;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge vmm_clk);
      cyc++;
    end while (!done_o && cyc < budget);
    if (!done_o) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge vmm_clk);
      n++;
    end while (!res_valid_o && n < budget);
    if (!res_valid_o) chk("valid_timeout", 0, 1);
  endtask

  task automatic load_pattern(input int p);
    for (int k = 0; k < (1 << IW); k++)  x_mem[k] = '0;
    for (int k = 0; k < (1 << WAW); k++) w_mem[k] = '0;
    for (int i = 0; i < L; i++) begin
      case (p)
        0:       x_mem[i] = OUT_W'(i + 1);
        1:       x_mem[i] = OUT_W'(1000 - 97 * i);
        default: x_mem[i] = '1;
      endcase
      for (int j = 0; j < M; j++) begin
        case (p)
          0:       w_mem[i*M + j] = OUT_W'(i + j);
          1:       w_mem[i*M + j] = OUT_W'(((i*M + j) * 37 + 5) % 1024);
          default: w_mem[i*M + j] = '1;
        endcase
      end
    end
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_state"},    32'(state_o), 0);
    chk({pfx, "_busy"},     32'(busy_o), 0);
    chk({pfx, "_done"},     32'(done_o), 0);
    chk({pfx, "_valid"},    32'(res_valid_o), 0);
    chk({pfx, "_mac_clr"},  32'(mac_clr_o), 0);
    chk({pfx, "_mac_en"},   32'(mac_en_o), 0);
    chk({pfx, "_x_addr"},   32'(x_addr_o), 0);
    chk({pfx, "_w_addr"},   32'(w_addr_o), 0);
    chk({pfx, "_res_data"}, 32'(res_data_o), 0);
    chk({pfx, "_res_col"},  32'(res_col_o), 0);
    chk({pfx, "_i"},        32'(i_o), 0);
    chk({pfx, "_j"},        32'(j_o), 0);
  endtask

  task automatic full_pass(input string pfx);
    int cyc;
    mark();
    pulse_start();
    wait_done(200, cyc);
    $display("%s: done_o at cycle %0d", pfx, cyc);
    chk({pfx, "_done_cycle"}, 32'(cyc), 66);
    tick();
    chk({pfx, "_results"}, 32'(res_cnt - pass_base), 32'(M));
    chk({pfx, "_mac_en_cycles"}, 32'(en_cnt - en_base), 32'(L * M));
    chk({pfx, "_done_cycles"}, 32'(done_cnt - done_base), 1);
    chk({pfx, "_idle_after"}, 32'(state_o), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int k;
    logic [OUT_W-1:0] held_data;
    logic [JW-1:0]    held_col;

    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    step_en_i = 1'b0; step_i = 1'b0; res_ready_i = 1'b1;
    load_pattern(0);
    #1;
    check_zero("rst_held");
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_zero("after_rst");

    // 1: free-running pass, timing and enable count
    load_pattern(0);
    chk("model_p0_col0", 32'(model_out(0)), 40);
    chk("model_p0_col4", 32'(model_out(4)), 100);
    full_pass("pass1");

    // 2: backpressure on column 2
    load_pattern(1);
    res_ready_i = 1'b0;
    mark();
    pulse_start();
    for (int c = 0; c < M; c++) begin
      wait_valid(100);
      if (c == 2) begin
        held_data = res_data_o;
        held_col  = res_col_o;
        repeat (10) begin
          @(negedge vmm_clk);
          chk("stall_valid", 32'(res_valid_o), 1);
          chk("stall_data", 32'(res_data_o), 32'(held_data));
          chk("stall_col", 32'(res_col_o), 32'(held_col));
          chk("stall_no_clr", 32'(mac_clr_o), 0);
        end
      end
      @(posedge vmm_clk); #1;
      res_ready_i = 1'b1;
      @(posedge vmm_clk); #1;
      res_ready_i = 1'b0;
    end
    tick();
    chk("bp_results", 32'(res_cnt - pass_base), 32'(M));
    chk("bp_done_cycles", 32'(done_cnt - done_base), 1);
    chk("bp_idle", 32'(state_o), 0);
    res_ready_i = 1'b1;

    // 3: step mode
    step_en_i = 1'b1;
    mark();
    pulse_start();
    repeat (20) tick();
    chk("step_frozen_state", 32'(state_o), 1);
    chk("step_frozen_no_en", 32'(en_cnt - en_base), 0);
    k = 0;
    while (busy_o && k < 400) begin
      step_i = 1'b1;
      tick();
      step_i = 1'b0;
      tick();
      tick();
      k++;
    end
    $display("step: %0d steps used", k);
    chk("step_finished", 32'(busy_o), 0);
    chk("step_mac_en_cycles", 32'(en_cnt - en_base), 32'(L * M));
    chk("step_results", 32'(res_cnt - pass_base), 32'(M));
    chk("step_saw_done", 32'(done_cnt != done_base), 1);
    step_en_i = 1'b0;

    // 4: abort during ACC of column 3, row 2
    load_pattern(0);
    mark();
    pulse_start();
    k = 0;
    do begin
      @(negedge vmm_clk);
      k++;
    end while (!(state_o == 3'd3 && j_o == 3 && i_o == 2) && k < 200);
    chk("abort_point_found", 32'(state_o == 3'd3 && j_o == 3 && i_o == 2), 1);
    abort_i = 1'b1;
    @(posedge vmm_clk); #1;
    abort_i = 1'b0;
    chk("abort_state", 32'(state_o), 0);
    chk("abort_valid", 32'(res_valid_o), 0);
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_i", 32'(i_o), 0);
    chk("abort_j", 32'(j_o), 0);
    chk("abort_keeps_data", 32'(res_data_o), 70);
    chk("abort_keeps_col", 32'(res_col_o), 2);
    repeat (3) tick();
    chk("abort_results", 32'(res_cnt - pass_base), 3);
    chk("abort_no_done", 32'(done_cnt - done_base), 0);
    full_pass("after_abort");

    // 5: start while busy is ignored; start+abort in IDLE is ignored
    load_pattern(1);
    mark();
    pulse_start();
    repeat (10) tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done(200, cyc);
    chk("restart_done_cycle", 32'(cyc), 55);
    tick();
    chk("restart_results", 32'(res_cnt - pass_base), 32'(M));
    chk("restart_done_cycles", 32'(done_cnt - done_base), 1);
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("start_abort_state", 32'(state_o), 0);
    chk("start_abort_busy", 32'(busy_o), 0);
    tick();
    chk("start_abort_still_idle", 32'(state_o), 0);

    // 6: asynchronous reset mid-OUT, then all-ones scoreboard pass
    load_pattern(2);
    chk("model_ones_col0", 32'(model_out(0)), 5);
    chk("model_ones_col3", 32'(model_out(3)), 5);
    res_ready_i = 1'b0;
    mark();
    pulse_start();
    wait_valid(100);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    @(posedge vmm_clk); #1;
    rst = 1'b0;
    tick();
    check_zero("async_rst_released");
    chk("async_rst_no_result", 32'(res_cnt - pass_base), 0);
    chk("async_rst_no_done", 32'(done_cnt - done_base), 0);
    res_ready_i = 1'b1;
    full_pass("ones");
    chk("ones_last_data", 32'(res_data_o), 5);
    chk("ones_last_col", 32'(res_col_o), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
